// File: rtl/icache_pkg.sv
// Shared geometry and refill FSM encoding for the instruction-cache refill path.
package icache_pkg;

  localparam int SET_BITS_WIDTH = 4;
  localparam int NUM_WAYS       = 4;
  localparam int WORD_WIDTH     = 20;
  localparam int NUM_LANES      = 4;
  localparam int WORDS_PER_LINE = 16;

  localparam int WAY_W         = $clog2(NUM_WAYS);
  localparam int LANE_W        = $clog2(NUM_LANES);
  localparam int BEAT_W        = $clog2(WORDS_PER_LINE);
  localparam int ROW_W         = BEAT_W - LANE_W;
  localparam int ROWS_PER_LINE = WORDS_PER_LINE / NUM_LANES;
  localparam int ROW_DATA_W    = WORD_WIDTH * NUM_LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } refill_state_e;

endpackage

// File: rtl/refill_row_packer.sv
// Packs in-order memory beats into full array rows and holds each row write
// until the data array accepts it; back-pressures memory while a row is stuck.
module refill_row_packer
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_en,
  input  logic                  i_beat_valid,
  input  logic [WORD_WIDTH-1:0] i_beat_data,
  output logic                  o_beat_ready,
  output logic                  o_beat_accept,
  output logic [BEAT_W-1:0]     o_beat_idx,
  input  logic                  i_array_ready,
  output logic                  o_w_valid,
  output logic [ROW_W-1:0]      o_w_row,
  output logic [ROW_DATA_W-1:0] o_w_data,
  output logic                  o_line_done
);

  logic [BEAT_W-1:0]     cnt_q, cnt_d;
  logic [ROW_DATA_W-1:0] pack_q, pack_d;
  logic [ROW_DATA_W-1:0] w_data_q, w_data_d;
  logic [ROW_W-1:0]      w_row_q, w_row_d;
  logic                  w_valid_q, w_valid_d;
  logic [LANE_W-1:0]     lane;
  logic                  accept;

  assign o_beat_ready  = i_en & ~(w_valid_q & ~i_array_ready);
  assign accept        = i_beat_valid & o_beat_ready;
  assign lane          = cnt_q[LANE_W-1:0];
  assign o_beat_accept = accept;
  assign o_beat_idx    = cnt_q;

  always_comb begin
    cnt_d     = cnt_q;
    pack_d    = pack_q;
    w_data_d  = w_data_q;
    w_row_d   = w_row_q;
    w_valid_d = w_valid_q;
    if (w_valid_q && i_array_ready) begin
      w_valid_d = 1'b0;
    end
    // A row loading in the same cycle the previous one drains keeps o_w_valid high.
    if (accept) begin
      cnt_d = cnt_q + 1'b1;
      pack_d[lane*WORD_WIDTH +: WORD_WIDTH] = i_beat_data;
      if (lane == LANE_W'(NUM_LANES - 1)) begin
        w_valid_d = 1'b1;
        w_row_d   = cnt_q[BEAT_W-1:LANE_W];
        w_data_d  = pack_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      cnt_q     <= '0;
      pack_q    <= '0;
      w_data_q  <= '0;
      w_row_q   <= '0;
      w_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pack_q    <= pack_d;
      w_data_q  <= w_data_d;
      w_row_q   <= w_row_d;
      w_valid_q <= w_valid_d;
    end
  end

  assign o_w_valid   = w_valid_q;
  assign o_w_row     = w_row_q;
  assign o_w_data    = w_data_q;
  assign o_line_done = w_valid_q & i_array_ready & (w_row_q == ROW_W'(ROWS_PER_LINE - 1));

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache refill sequencer: miss -> memory line request -> packed row writes -> done pulse.
// Build macro ICACHE_REFILL_BYPASS_EN adds a requested-word bypass output.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int TAG_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                arst_n,
  input  logic                                i_miss_valid,
  input  logic [TAG_WIDTH-1:0]                i_miss_tag,
  input  logic [SET_BITS_WIDTH-1:0]           i_miss_set,
  input  logic [WAY_W-1:0]                    i_miss_way,
  input  logic [BEAT_W-1:0]                   i_miss_offset,
  output logic                                o_miss_ready,
  output logic                                o_mem_req_valid,
  output logic [TAG_WIDTH+SET_BITS_WIDTH-1:0] o_mem_req_addr,
  input  logic                                i_mem_req_ready,
  input  logic                                i_mem_resp_valid,
  input  logic [WORD_WIDTH-1:0]               i_mem_resp_data,
  output logic                                o_mem_resp_ready,
  output logic                                o_w_valid,
  output logic [SET_BITS_WIDTH-1:0]           o_w_set_bits,
  output logic [WAY_W-1:0]                    o_w_way_index,
  output logic [ROW_W-1:0]                    o_w_block_offset_bits,
  output logic [ROW_DATA_W-1:0]               o_w_data,
  input  logic                                i_array_ready,
  output logic                                o_busy,
  output logic [SET_BITS_WIDTH-1:0]           o_busy_set,
  output logic [WAY_W-1:0]                    o_busy_way,
  output logic                                o_fill_done,
  output logic [SET_BITS_WIDTH-1:0]           o_fill_set,
`ifdef ICACHE_REFILL_BYPASS_EN
  output logic                                o_bypass_valid,
  output logic [WORD_WIDTH-1:0]               o_bypass_data,
`endif
  output logic [WAY_W-1:0]                    o_fill_way
);

  refill_state_e               state_q, state_d;
  logic [TAG_WIDTH-1:0]        tag_q, tag_d;
  logic [SET_BITS_WIDTH-1:0]   set_q, set_d;
  logic [WAY_W-1:0]            way_q, way_d;
  logic [BEAT_W-1:0]           off_q, off_d;
  logic                        miss_ready_q, miss_ready_d;
  logic                        req_valid_q, req_valid_d;
  logic                        busy_q, busy_d;
  logic                        fill_done_q, fill_done_d;

  logic                        line_done;
  logic                        beat_accept;
  logic [BEAT_W-1:0]           beat_idx;

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    set_d   = set_q;
    way_d   = way_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        if (i_miss_valid) begin
          tag_d   = i_miss_tag;
          set_d   = i_miss_set;
          way_d   = i_miss_way;
          off_d   = i_miss_offset;
          state_d = REQ;
        end
      end
      REQ:     if (i_mem_req_ready) state_d = FILL;
      FILL:    if (line_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    miss_ready_d = (state_d == IDLE);
    req_valid_d  = (state_d == REQ);
    busy_d       = (state_d != IDLE);
    fill_done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      set_q        <= '0;
      way_q        <= '0;
      off_q        <= '0;
      miss_ready_q <= 1'b1;
      req_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      fill_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      set_q        <= set_d;
      way_q        <= way_d;
      off_q        <= off_d;
      miss_ready_q <= miss_ready_d;
      req_valid_q  <= req_valid_d;
      busy_q       <= busy_d;
      fill_done_q  <= fill_done_d;
    end
  end

  refill_row_packer u_packer (
    .clk          (clk),
    .arst_n       (arst_n),
    .i_en         (state_q == FILL),
    .i_beat_valid (i_mem_resp_valid),
    .i_beat_data  (i_mem_resp_data),
    .o_beat_ready (o_mem_resp_ready),
    .o_beat_accept(beat_accept),
    .o_beat_idx   (beat_idx),
    .i_array_ready(i_array_ready),
    .o_w_valid    (o_w_valid),
    .o_w_row      (o_w_block_offset_bits),
    .o_w_data     (o_w_data),
    .o_line_done  (line_done)
  );

`ifdef ICACHE_REFILL_BYPASS_EN
  logic                  byp_valid_q, byp_valid_d;
  logic [WORD_WIDTH-1:0] byp_data_q, byp_data_d;

  always_comb begin
    byp_valid_d = beat_accept && (beat_idx == off_q);
    byp_data_d  = byp_valid_d ? i_mem_resp_data : byp_data_q;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      byp_valid_q <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      byp_valid_q <= byp_valid_d;
      byp_data_q  <= byp_data_d;
    end
  end

  assign o_bypass_valid = byp_valid_q;
  assign o_bypass_data  = byp_data_q;
`else
  logic unused_bypass;
  assign unused_bypass = ^{off_q, beat_accept, beat_idx};
`endif

  assign o_miss_ready    = miss_ready_q;
  assign o_mem_req_valid = req_valid_q;
  assign o_mem_req_addr  = {tag_q, set_q};
  assign o_w_set_bits    = set_q;
  assign o_w_way_index   = way_q;
  assign o_busy          = busy_q;
  assign o_busy_set      = set_q;
  assign o_busy_way      = way_q;
  assign o_fill_done     = fill_done_q;
  assign o_fill_set      = set_q;
  assign o_fill_way      = way_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: table of refill scenarios plus a mid-fill reset sequence,
// with a row-write scoreboard fed at miss time and drained as rows are consumed.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        i_miss_valid;
  logic [7:0]  i_miss_tag;
  logic [3:0]  i_miss_set;
  logic [1:0]  i_miss_way;
  logic [3:0]  i_miss_offset;
  logic        o_miss_ready;
  logic        o_mem_req_valid;
  logic [11:0] o_mem_req_addr;
  logic        i_mem_req_ready;
  logic        i_mem_resp_valid;
  logic [19:0] i_mem_resp_data;
  logic        o_mem_resp_ready;
  logic        o_w_valid;
  logic [3:0]  o_w_set_bits;
  logic [1:0]  o_w_way_index;
  logic [1:0]  o_w_block_offset_bits;
  logic [79:0] o_w_data;
  logic        i_array_ready;
  logic        o_busy;
  logic [3:0]  o_busy_set;
  logic [1:0]  o_busy_way;
  logic        o_fill_done;
  logic [3:0]  o_fill_set;
  logic [1:0]  o_fill_way;
`ifdef ICACHE_REFILL_BYPASS_EN
  logic        o_bypass_valid;
  logic [19:0] o_bypass_data;
`endif

  always #5 clk = ~clk;

  icache_refill_ctrl #(.TAG_WIDTH(8)) dut (
    .clk                  (clk),
    .arst_n               (arst_n),
    .i_miss_valid         (i_miss_valid),
    .i_miss_tag           (i_miss_tag),
    .i_miss_set           (i_miss_set),
    .i_miss_way           (i_miss_way),
    .i_miss_offset        (i_miss_offset),
    .o_miss_ready         (o_miss_ready),
    .o_mem_req_valid      (o_mem_req_valid),
    .o_mem_req_addr       (o_mem_req_addr),
    .i_mem_req_ready      (i_mem_req_ready),
    .i_mem_resp_valid     (i_mem_resp_valid),
    .i_mem_resp_data      (i_mem_resp_data),
    .o_mem_resp_ready     (o_mem_resp_ready),
    .o_w_valid            (o_w_valid),
    .o_w_set_bits         (o_w_set_bits),
    .o_w_way_index        (o_w_way_index),
    .o_w_block_offset_bits(o_w_block_offset_bits),
    .o_w_data             (o_w_data),
    .i_array_ready        (i_array_ready),
    .o_busy               (o_busy),
    .o_busy_set           (o_busy_set),
    .o_busy_way           (o_busy_way),
    .o_fill_done          (o_fill_done),
    .o_fill_set           (o_fill_set),
`ifdef ICACHE_REFILL_BYPASS_EN
    .o_bypass_valid       (o_bypass_valid),
    .o_bypass_data        (o_bypass_data),
`endif
    .o_fill_way           (o_fill_way)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  row;
    logic [79:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  logic [3:0] cur_set;
  logic [1:0] cur_way;
  int   byp_pulses;

  bit          pend_row = 1'b0;
  bit          pend_byp = 1'b0;
  logic [1:0]  pend_row_idx;
  logic [19:0] pend_byp_data;

  typedef struct {
    logic [7:0]  tag;
    logic [3:0]  set;
    logic [1:0]  way;
    logic [3:0]  off;
    logic [19:0] base;
    int          gap;
    int          req_stall;
    int          halt_row;
    int          halt_cyc;
    logic [11:0] exp_addr;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard drain: a row is consumed at the next edge when valid and ready.
  always @(negedge clk) begin
    if (o_w_valid && i_array_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w_unexpected actual_row=%0d required=none", o_w_block_offset_bits);
      end else begin
        mon_e = exp_q.pop_front();
        chk("w_row", 80'(o_w_block_offset_bits), 80'(mon_e.row));
        chk("w_data", o_w_data, mon_e.data);
        chk("w_set", 80'(o_w_set_bits), 80'(cur_set));
        chk("w_way", 80'(o_w_way_index), 80'(cur_way));
      end
    end
`ifdef ICACHE_REFILL_BYPASS_EN
    if (o_bypass_valid) byp_pulses++;
`endif
  end

  task automatic do_pending();
    if (pend_row) begin
      chk("row_latency_valid", 80'(o_w_valid), 80'd1);
      chk("row_latency_idx", 80'(o_w_block_offset_bits), 80'(pend_row_idx));
    end
`ifdef ICACHE_REFILL_BYPASS_EN
    if (pend_byp) begin
      chk("bypass_valid", 80'(o_bypass_valid), 80'd1);
      chk("bypass_data", 80'(o_bypass_data), 80'(pend_byp_data));
    end
`endif
    pend_row = 1'b0;
    pend_byp = 1'b0;
  endtask

  task automatic send_beats(input logic [19:0] base, input int first, input int cnt,
                            input int gap, input bit lat, input logic [3:0] off);
    bit acc;
    for (int i = first; i < first + cnt; i++) begin
      for (int g = 0; g < gap; g++) begin
        i_mem_resp_valid = 1'b0;
        @(negedge clk);
        do_pending();
        step();
      end
      i_mem_resp_valid = 1'b1;
      i_mem_resp_data  = base + 20'(i);
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge clk);
        do_pending();
        acc = o_mem_resp_ready;
        step();
      end
      if (!acc) chk("beat_accept_timeout", 80'd0, 80'd1);
      pend_row      = lat && (i % 4 == 3);
      pend_row_idx  = 2'(i / 4);
      pend_byp      = (4'(i) == off);
      pend_byp_data = base + 20'(i);
    end
    i_mem_resp_valid = 1'b0;
    if (pend_row || pend_byp) begin
      @(negedge clk);
      do_pending();
      step();
    end
  endtask

  task automatic halter(input int hrow, input int hcyc);
    logic [79:0] held;
    int n;
    bit seen;
    if (hrow < 0) return;
    if (hrow > 0) begin
      seen = 1'b0;
      for (int t = 0; t < 500 && !seen; t++) begin
        @(negedge clk);
        seen = o_w_valid && (o_w_block_offset_bits == 2'(hrow - 1));
      end
      if (!seen) chk("halt_prev_row_timeout", 80'd0, 80'd1);
      step();
    end
    i_array_ready = 1'b0;
    n = 0;
    held = '0;
    for (int t = 0; t < 500 && n < hcyc; t++) begin
      @(negedge clk);
      if (o_w_valid) begin
        if (n == 0) held = o_w_data;
        else chk("halt_data_held", o_w_data, held);
        chk("halt_row", 80'(o_w_block_offset_bits), 80'(hrow));
        chk("halt_resp_ready", 80'(o_mem_resp_ready), 80'd0);
        n++;
      end
    end
    chk("halt_cycles", 80'(n), 80'(hcyc));
    step();
    i_array_ready = 1'b1;
  endtask

  task automatic push_rows(input logic [19:0] base, input int nrows);
    wr_t e;
    for (int r = 0; r < nrows; r++) begin
      e.row = 2'(r);
      for (int k = 0; k < 4; k++) e.data[k*20 +: 20] = base + 20'(4 * r + k);
      exp_q.push_back(e);
    end
  endtask

  task automatic accept_miss(input vec_t v);
    chk("miss_ready_idle", 80'(o_miss_ready), 80'd1);
    i_miss_valid  = 1'b1;
    i_miss_tag    = v.tag;
    i_miss_set    = v.set;
    i_miss_way    = v.way;
    i_miss_offset = v.off;
    step();
    i_miss_valid  = 1'b0;
    i_miss_tag    = ~v.tag;
    i_miss_set    = ~v.set;
    i_miss_way    = ~v.way;
    i_miss_offset = ~v.off;
    chk("req_valid", 80'(o_mem_req_valid), 80'd1);
    chk("req_addr", 80'(o_mem_req_addr), 80'(v.exp_addr));
    chk("miss_ready_busy", 80'(o_miss_ready), 80'd0);
    chk("busy", 80'(o_busy), 80'd1);
    chk("busy_set", 80'(o_busy_set), 80'(v.set));
    chk("busy_way", 80'(o_busy_way), 80'(v.way));
    // A beat offered before the request is accepted must be refused.
    i_mem_resp_valid = 1'b1;
    i_mem_resp_data  = 20'hDEAD0;
    chk("resp_ready_in_req", 80'(o_mem_resp_ready), 80'd0);
    for (int s = 0; s < v.req_stall; s++) begin
      step();
      chk("req_stall_valid", 80'(o_mem_req_valid), 80'd1);
      chk("req_stall_addr", 80'(o_mem_req_addr), 80'(v.exp_addr));
      chk("req_stall_miss_ready", 80'(o_miss_ready), 80'd0);
      chk("req_stall_busy_set", 80'(o_busy_set), 80'(v.set));
      chk("req_stall_resp_ready", 80'(o_mem_resp_ready), 80'd0);
    end
    i_mem_resp_valid = 1'b0;
    i_mem_req_ready  = 1'b1;
    step();
    i_mem_req_ready  = 1'b0;
    chk("req_dropped", 80'(o_mem_req_valid), 80'd0);
  endtask

  task automatic run_vec(input vec_t v);
    bit empty;
    cur_set    = v.set;
    cur_way    = v.way;
    byp_pulses = 0;
    push_rows(v.base, 4);
    accept_miss(v);
    fork
      send_beats(v.base, 0, 16, v.gap, (v.halt_row < 0), v.off);
      halter(v.halt_row, v.halt_cyc);
    join
    empty = 1'b0;
    for (int t = 0; t < 200 && !empty; t++) begin
      if (exp_q.size() == 0) empty = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    chk("all_rows_written", 80'(empty), 80'd1);
    @(negedge clk);
    chk("fill_done", 80'(o_fill_done), 80'd1);
    chk("fill_set", 80'(o_fill_set), 80'(v.set));
    chk("fill_way", 80'(o_fill_way), 80'(v.way));
    chk("busy_in_done", 80'(o_busy), 80'd1);
    @(negedge clk);
    chk("fill_done_one_cycle", 80'(o_fill_done), 80'd0);
    chk("miss_ready_after", 80'(o_miss_ready), 80'd1);
    chk("busy_after", 80'(o_busy), 80'd0);
`ifdef ICACHE_REFILL_BYPASS_EN
    chk("bypass_pulse_count", 80'(byp_pulses), 80'd1);
`endif
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;

    //                 tag    set   way   off    base      gap stall halt_row halt_cyc addr
    vecs[0] = '{8'h5A, 4'h3, 2'd2, 4'd6,  20'h00000, 0, 0, -1, 0, 12'h5A3};
    vecs[1] = '{8'hC3, 4'h7, 2'd1, 4'd0,  20'hABC00, 0, 0,  1, 5, 12'hC37};
    vecs[2] = '{8'h11, 4'h3, 2'd0, 4'd15, 20'h12340, 0, 3, -1, 0, 12'h113};
    vecs[3] = '{8'hFF, 4'hF, 2'd3, 4'd9,  20'hFFFF0, 2, 0, -1, 0, 12'hFFF};

    arst_n           = 1'b0;
    i_miss_valid     = 1'b0;
    i_miss_tag       = '0;
    i_miss_set       = '0;
    i_miss_way       = '0;
    i_miss_offset    = '0;
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b0;
    i_mem_resp_data  = '0;
    i_array_ready    = 1'b1;
    cur_set          = '0;
    cur_way          = '0;
    byp_pulses       = 0;
    repeat (3) step();

    chk("rst_miss_ready", 80'(o_miss_ready), 80'd1);
    chk("rst_req_valid", 80'(o_mem_req_valid), 80'd0);
    chk("rst_req_addr", 80'(o_mem_req_addr), 80'd0);
    chk("rst_resp_ready", 80'(o_mem_resp_ready), 80'd0);
    chk("rst_w_valid", 80'(o_w_valid), 80'd0);
    chk("rst_w_data", o_w_data, 80'd0);
    chk("rst_busy", 80'(o_busy), 80'd0);
    chk("rst_fill_done", 80'(o_fill_done), 80'd0);
    arst_n = 1'b1;
    step();

    // Reset after beat 9: rows 0 and 1 land, the rest of the line is abandoned.
    rv         = '{8'h2D, 4'h9, 2'd1, 4'd3, 20'h40000, 0, 0, -1, 0, 12'h2D9};
    cur_set    = rv.set;
    cur_way    = rv.way;
    push_rows(rv.base, 2);
    accept_miss(rv);
    send_beats(rv.base, 0, 10, 0, 1'b0, rv.off);
    i_mem_resp_valid = 1'b1;
    i_mem_resp_data  = rv.base + 20'd10;
    arst_n = 1'b0;
    step();
    arst_n = 1'b1;
    chk("midrst_rows_before", 80'(exp_q.size()), 80'd0);
    exp_q.delete();
    chk("midrst_miss_ready", 80'(o_miss_ready), 80'd1);
    chk("midrst_busy", 80'(o_busy), 80'd0);
    chk("midrst_busy_set", 80'(o_busy_set), 80'd0);
    chk("midrst_req_valid", 80'(o_mem_req_valid), 80'd0);
    chk("midrst_req_addr", 80'(o_mem_req_addr), 80'd0);
    chk("midrst_w_valid", 80'(o_w_valid), 80'd0);
    chk("midrst_w_data", o_w_data, 80'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("midrst_resp_ready", 80'(o_mem_resp_ready), 80'd0);
      chk("midrst_no_done", 80'(o_fill_done), 80'd0);
      chk("midrst_no_write", 80'(o_w_valid), 80'd0);
      step();
    end
    i_mem_resp_valid = 1'b0;
    step();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
